pc_fetch_ctrl: RTL and testbench

//  Fetch sequencer that owns the program counter. Issues instruction-memory

---
 rtl/pc_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues req/ack instruction fetches, hands words to decode, applies redirects.
// Optional branch statistics counters are built only when BRANCH_STATS_EN is defined.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   input  logic             id_ready,
   input  logic             stall,
   input  logic             branch,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   output logic             redirect,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] br_taken_count
);

   typedef enum logic [1:0] {RST, FETCH, HOLD, DRAIN} state_t;

   state_t      state, state_next;
   logic [31:0] pc;
   logic [31:0] drain_addr;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        valid_q;
   logic        redirect_q;
   logic        redir;
   logic        consume;
   logic [31:0] redir_target;

   assign redir        = (state != RST) && (jump || branch_taken);
   assign redir_target = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
   assign consume      = (state == HOLD) && valid_q && id_ready && !stall;

   // An outstanding request keeps its original address in DRAIN even after the PC moves on.
   assign imem_req  = (state == FETCH) || (state == DRAIN);
   assign imem_addr = (state == DRAIN) ? drain_addr : pc;
   assign if_valid  = valid_q;
   assign if_instr  = valid_q ? instr_q : NOP_INSTR;
   assign if_pc     = pc_q;
   assign redirect  = redirect_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RST:   state_next = FETCH;
         FETCH: begin
            if (redir)         state_next = imem_ack ? FETCH : DRAIN;
            else if (imem_ack) state_next = HOLD;
         end
         HOLD:  if (redir || consume) state_next = FETCH;
         DRAIN: if (imem_ack) state_next = FETCH;
         default: state_next = RST;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
      end else begin
         redirect_q <= redir;
         if (redir) begin
            pc      <= redir_target;
            valid_q <= 1'b0;
         end
         case (state)
            FETCH: begin
               if (!redir && imem_ack) begin
                  instr_q <= imem_rdata;
                  pc_q    <= pc;
                  valid_q <= 1'b1;
                  pc      <= pc + 32'd4;
               end else if (redir && !imem_ack) begin
                  drain_addr <= pc;
               end
            end
            HOLD: if (!redir && consume) valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   // Saturating counters: they stop at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count       <= '0;
         br_taken_count <= '0;
      end else begin
         if (branch && (br_count != '1))
            br_count <= br_count + CNT_W'(1);
         if (branch && branch_taken && (br_taken_count != '1))
            br_taken_count <= br_taken_count + CNT_W'(1);
      end
   end
`else
   logic unused_branch;
   assign unused_branch  = branch;
   assign br_count       = '0;
   assign br_taken_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; inputs change and outputs are checked on the falling edge.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        stall;
   logic        branch;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        redirect;
   logic [1:0]  br_count;
   logic [1:0]  br_taken_count;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   pc_fetch_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready), .stall(stall),
      .branch(branch), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .redirect(redirect),
      .br_count(br_count), .br_taken_count(br_taken_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ack, input logic [31:0] rdata);
      imem_ack   = ack;
      imem_rdata = rdata;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; id_ready = 0; stall = 0;
      branch = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
      nextCycle(); nextCycle();
      checkOutput("rst_req", 32'(imem_req), 0);
      checkOutput("rst_addr", imem_addr, 0);
      checkOutput("rst_valid", 32'(if_valid), 0);
      checkOutput("rst_instr", if_instr, NOP);
      checkOutput("rst_pc", if_pc, 0);
      checkOutput("rst_redirect", 32'(redirect), 0);
      checkOutput("rst_brcnt", 32'(br_count), 0);
      rst_n = 1'b1;

      // Back-to-back fetches with ack in the request cycle
      nextCycle();
      checkOutput("f0_req", 32'(imem_req), 1);
      checkOutput("f0_addr", imem_addr, 32'h0);
      applyStimulus(1, 32'hA000_0000); id_ready = 1;
      nextCycle();
      checkOutput("f0_valid", 32'(if_valid), 1);
      checkOutput("f0_pc", if_pc, 32'h0);
      checkOutput("f0_instr", if_instr, 32'hA000_0000);
      checkOutput("f0_req_hold", 32'(imem_req), 0);
      applyStimulus(0, 0);
      nextCycle();
      checkOutput("f1_addr", imem_addr, 32'h4);
      checkOutput("f1_valid_low", 32'(if_valid), 0);
      applyStimulus(1, 32'hA000_0004);
      nextCycle();
      checkOutput("f1_pc", if_pc, 32'h4);
      checkOutput("f1_instr", if_instr, 32'hA000_0004);
      applyStimulus(0, 0);
      nextCycle();
      checkOutput("f2_addr", imem_addr, 32'h8);
      applyStimulus(1, 32'hA000_0008);
      nextCycle();
      checkOutput("f2_pc", if_pc, 32'h8);
      checkOutput("f2_valid", 32'(if_valid), 1);
      applyStimulus(0, 0);

      // Ack delayed three cycles: request and address must hold steady
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         checkOutput("dly_req", 32'(imem_req), 1);
         checkOutput("dly_addr", imem_addr, 32'hC);
         checkOutput("dly_valid", 32'(if_valid), 0);
      end
      nextCycle();
      checkOutput("dly_addr4", imem_addr, 32'hC);
      applyStimulus(1, 32'h0000_00BC);
      nextCycle();
      checkOutput("dly_valid1", 32'(if_valid), 1);
      checkOutput("dly_pc", if_pc, 32'hC);
      applyStimulus(0, 0);

      // Stall blocks consumption; then a taken branch in HOLD at pc 0x10
      stall = 1;
      nextCycle();
      checkOutput("stall_valid", 32'(if_valid), 1);
      checkOutput("stall_instr", if_instr, 32'h0000_00BC);
      branch = 1; branch_taken = 1; branch_target = 32'h40;
      nextCycle();
      checkOutput("br_redirect", 32'(redirect), 1);
      checkOutput("br_valid", 32'(if_valid), 0);
      checkOutput("br_instr", if_instr, NOP);
      checkOutput("br_addr", imem_addr, 32'h40);
      branch = 0; branch_taken = 0; stall = 0;
      nextCycle();
      checkOutput("br_redirect_off", 32'(redirect), 0);
      applyStimulus(1, 32'h0000_0D40);
      nextCycle();
      checkOutput("br_fetch_pc", if_pc, 32'h40);
      applyStimulus(0, 0);

      // Jump in HOLD drops the word even when consumed; target low bits are cleared
      jump = 1; jump_target = 32'h22;
      nextCycle();
      checkOutput("j_redirect", 32'(redirect), 1);
      checkOutput("j_valid", 32'(if_valid), 0);
      checkOutput("j_addr", imem_addr, 32'h20);
      // Jump while 0x20 is outstanding: request keeps 0x20 until ack
      jump_target = 32'h80;
      nextCycle();
      jump = 0;
      checkOutput("drain_redirect", 32'(redirect), 1);
      checkOutput("drain_req", 32'(imem_req), 1);
      checkOutput("drain_addr", imem_addr, 32'h20);
      nextCycle();
      checkOutput("drain_addr2", imem_addr, 32'h20);
      checkOutput("drain_redirect_off", 32'(redirect), 0);
      applyStimulus(1, 32'hDEAD_0020);
      nextCycle();
      checkOutput("drain_valid", 32'(if_valid), 0);
      checkOutput("drain_next_addr", imem_addr, 32'h80);
      applyStimulus(0, 0);

      // Jump and taken branch together: jump wins
      jump = 1; jump_target = 32'h100; branch = 1; branch_taken = 1; branch_target = 32'h200;
      nextCycle();
      jump = 0; branch = 0; branch_taken = 0;
      checkOutput("prio_drain_addr", imem_addr, 32'h80);
      applyStimulus(1, 32'hDEAD_0080);
      nextCycle();
      checkOutput("prio_addr", imem_addr, 32'h100);
      checkOutput("prio_valid", 32'(if_valid), 0);
      applyStimulus(1, 32'h0000_1234);
      nextCycle();
      checkOutput("prio_pc", if_pc, 32'h100);
      checkOutput("prio_instr", if_instr, 32'h0000_1234);
      applyStimulus(0, 0);
      nextCycle();
      checkOutput("seq_addr", imem_addr, 32'h104);

      // Redirect with ack in the same cycle drops data; then PC wrap
      jump = 1; jump_target = 32'hFFFF_FFFF;
      applyStimulus(1, 32'hBAD0_0104);
      nextCycle();
      jump = 0;
      checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      checkOutput("wrap_drop_valid", 32'(if_valid), 0);
      applyStimulus(1, 32'h0000_0055);
      nextCycle();
      checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);
      applyStimulus(0, 0);
      nextCycle();
      checkOutput("wrap_next", imem_addr, 32'h0);

      // Three untaken branches on top of two taken ones
      branch = 1;
      nextCycle(); nextCycle(); nextCycle();
      branch = 0;
`ifdef BRANCH_STATS_EN
      checkOutput("stat_br", 32'(br_count), 3);
      checkOutput("stat_taken", 32'(br_taken_count), 2);
`else
      checkOutput("stat_br", 32'(br_count), 0);
      checkOutput("stat_taken", 32'(br_taken_count), 0);
`endif

      // Reset during an outstanding fetch with ack present
      applyStimulus(1, 32'hBAD0_0000);
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_req", 32'(imem_req), 0);
      checkOutput("mrst_valid", 32'(if_valid), 0);
      nextCycle();
      checkOutput("mrst_brcnt", 32'(br_count), 0);
      checkOutput("mrst_addr", imem_addr, 32'h0);
      applyStimulus(0, 0);
      rst_n = 1'b1;
      nextCycle();
      checkOutput("mrst_restart_req", 32'(imem_req), 1);
      checkOutput("mrst_restart_addr", imem_addr, 32'h0);
      checkOutput("mrst_restart_valid", 32'(if_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
